// File: rtl/thread_rf_pkg.sv
// Shared defaults, derived widths and types for the multi-thread register file.
// The optional RF_BYPASS_EN macro (see thread_regfile) does not affect this package.
package thread_rf_pkg;

  localparam int DEF_DATA_W   = 28;
  localparam int DEF_NREGS    = 16;
  localparam int DEF_NTHREADS = 4;

  // A single-thread build still needs a 1-bit tid port.
  function automatic int tid_width(input int nthreads);
    return (nthreads > 1) ? $clog2(nthreads) : 1;
  endfunction

  localparam int DEF_REG_W = $clog2(DEF_NREGS);
  localparam int DEF_TID_W = tid_width(DEF_NTHREADS);

  typedef logic [DEF_TID_W-1:0]  tid_t;
  typedef logic [DEF_REG_W-1:0]  reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-thread pending bits for outstanding loads.
// Priority: mark beats port-B clear and flush; bit 0 of every thread is always 0.
module rf_scoreboard
  import thread_rf_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int NTHREADS = DEF_NTHREADS,
  parameter int REG_W    = $clog2(NREGS),
  parameter int TID_W    = tid_width(NTHREADS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mark_en,
  input  logic [TID_W-1:0]                 mark_tid,
  input  logic [REG_W-1:0]                 mark_reg,
  input  logic                             clr_en,
  input  logic [TID_W-1:0]                 clr_tid,
  input  logic [REG_W-1:0]                 clr_reg,
  input  logic                             flush_en,
  input  logic [TID_W-1:0]                 flush_tid,
  output logic [NTHREADS-1:0][NREGS-1:0]   pend
);

  logic [NTHREADS-1:0][NREGS-1:0] pend_next;

  always_comb begin
    pend_next = pend;
    for (int t = 0; t < NTHREADS; t++) begin
      if (flush_en && flush_tid == TID_W'(t))
        pend_next[t] = '0;
      if (clr_en && clr_tid == TID_W'(t))
        pend_next[t][clr_reg] = 1'b0;
      // Applied last so a same-cycle mark survives both clear and flush.
      if (mark_en && mark_tid == TID_W'(t))
        pend_next[t][mark_reg] = 1'b1;
      pend_next[t][0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else
      pend <= pend_next;
  end

endmodule

// File: rtl/thread_regfile.sv
// Multi-thread register file: NTHREADS banks, 2 read / 2 write ports, load scoreboard.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding and bypassed hazard clears.
// Interface has no handshakes: every enable is a single-cycle command sampled on the rising edge.
module thread_regfile
  import thread_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int NTHREADS = DEF_NTHREADS,
  parameter int REG_W    = $clog2(NREGS),
  parameter int TID_W    = tid_width(NTHREADS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TID_W-1:0]  rd_tid,
  input  logic [REG_W-1:0]  rs0,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rd_dst,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1,
  output logic              hazard,
  input  logic              wa_en,
  input  logic [TID_W-1:0]  wa_tid,
  input  logic [REG_W-1:0]  wa_reg,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [TID_W-1:0]  wb_tid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mark_en,
  input  logic [TID_W-1:0]  mark_tid,
  input  logic [REG_W-1:0]  mark_reg,
  input  logic              flush_en,
  input  logic [TID_W-1:0]  flush_tid,
  output logic              err
);

  // Register 0 has no storage; reads of it are forced to zero below.
  logic [DATA_W-1:0] mem [NTHREADS][1:NREGS-1];

  logic [NTHREADS-1:0][NREGS-1:0] pend;
  logic wa_live, wb_live, collision;

  assign wa_live   = wa_en && (wa_reg != '0);
  assign wb_live   = wb_en && (wb_reg != '0);
  assign collision = wa_live && wb_live && (wa_tid == wb_tid) && (wa_reg == wb_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++)
        for (int r = 1; r < NREGS; r++)
          mem[t][r] <= '0;
    end else begin
      if (wb_live && !collision)
        mem[wb_tid][wb_reg] <= wb_data;
      if (wa_live)
        mem[wa_tid][wa_reg] <= wa_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (collision)
      err <= 1'b1;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NTHREADS (NTHREADS),
    .REG_W    (REG_W),
    .TID_W    (TID_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .mark_en   (mark_en),
    .mark_tid  (mark_tid),
    .mark_reg  (mark_reg),
    .clr_en    (wb_en),
    .clr_tid   (wb_tid),
    .clr_reg   (wb_reg),
    .flush_en  (flush_en),
    .flush_tid (flush_tid),
    .pend      (pend)
  );

  logic [REG_W-1:0]  rs_sel   [2];
  logic [DATA_W-1:0] dout_sel [2];

  assign rs_sel[0] = rs0;
  assign rs_sel[1] = rs1;
  assign dout0     = dout_sel[0];
  assign dout1     = dout_sel[1];

  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      dout_sel[p] = '0;
      if (rs_sel[p] != '0) begin
        dout_sel[p] = mem[rd_tid][rs_sel[p]];
`ifdef RF_BYPASS_EN
        if (wa_en && wa_tid == rd_tid && wa_reg == rs_sel[p])
          dout_sel[p] = wa_data;
        else if (wb_en && wb_tid == rd_tid && wb_reg == rs_sel[p])
          dout_sel[p] = wb_data;
`endif
      end
    end
  end

  logic [NREGS-1:0] pend_view;

  always_comb begin
    pend_view = pend[rd_tid];
`ifdef RF_BYPASS_EN
    // A port-B return clears the hazard now unless a same-cycle mark re-arms it.
    if (wb_en && wb_tid == rd_tid &&
        !(mark_en && mark_tid == wb_tid && mark_reg == wb_reg))
      pend_view[wb_reg] = 1'b0;
`endif
    pend_view[0] = 1'b0;
  end

  assign hazard = pend_view[rs0] | pend_view[rs1] | pend_view[rd_dst];

endmodule

// File: tb/tb_thread_regfile.sv
// Directed self-checking bench for thread_regfile (default build; RF_BYPASS_EN-aware in the wb cycle).
module tb_thread_regfile;
  import thread_rf_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  tid_t     rd_tid = '0;
  reg_idx_t rs0 = '0, rs1 = '0, rd_dst = '0;
  word_t    dout0, dout1;
  logic     hazard, err;
  logic     wa_en = 1'b0, wb_en = 1'b0, mark_en = 1'b0, flush_en = 1'b0;
  tid_t     wa_tid = '0, wb_tid = '0, mark_tid = '0, flush_tid = '0;
  reg_idx_t wa_reg = '0, wb_reg = '0, mark_reg = '0;
  word_t    wa_data = '0, wb_data = '0;

  int total_cnt = 0;
  int pass_cnt  = 0;

  thread_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rd_tid    (rd_tid),
    .rs0       (rs0),
    .rs1       (rs1),
    .rd_dst    (rd_dst),
    .dout0     (dout0),
    .dout1     (dout1),
    .hazard    (hazard),
    .wa_en     (wa_en),
    .wa_tid    (wa_tid),
    .wa_reg    (wa_reg),
    .wa_data   (wa_data),
    .wb_en     (wb_en),
    .wb_tid    (wb_tid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .mark_en   (mark_en),
    .mark_tid  (mark_tid),
    .mark_reg  (mark_reg),
    .flush_en  (flush_en),
    .flush_tid (flush_tid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply whatever is on the inputs at one rising edge, then settle 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; mark_en = 1'b0; flush_en = 1'b0;
  endtask

  task automatic rd(input int tid, input int a, input int b, input int d);
    rd_tid = tid_t'(tid); rs0 = reg_idx_t'(a); rs1 = reg_idx_t'(b); rd_dst = reg_idx_t'(d);
    #1;
  endtask

  initial begin
    // Reset then read
    #12 rst = 1'b0;
    rd(2, 5, 0, 0);
    check("rst_dout0", dout0, 0);
    check("rst_dout1", dout1, 0);
    check("rst_hazard", hazard, 0);
    check("rst_err", err, 0);

    // Port A write tid1 r3
    wa_en = 1; wa_tid = 1; wa_reg = 3; wa_data = 28'h0ABCDEF;
    cyc(); idle();
    rd(1, 3, 0, 0);
    check("wa_t1r3", dout0, 28'h0ABCDEF);
    rd(0, 3, 0, 0);
    check("wa_t0r3_iso", dout0, 0);

    // Write to r0 is discarded
    wa_en = 1; wa_tid = 1; wa_reg = 0; wa_data = 28'hFFFFFFF;
    cyc(); idle();
    rd(1, 0, 3, 0);
    check("r0_zero", dout0, 0);
    check("r0_no_alias", dout1, 28'h0ABCDEF);

    // Both ports targeting r0 of the same tid: no error
    wa_en = 1; wa_tid = 0; wa_reg = 0; wa_data = 28'h1;
    wb_en = 1; wb_tid = 0; wb_reg = 0; wb_data = 28'h2;
    cyc(); idle();
    check("r0_no_err", err, 0);

    // Different targets both complete
    wa_en = 1; wa_tid = 2; wa_reg = 15; wa_data = 28'hFFFFFFF;
    wb_en = 1; wb_tid = 3; wb_reg = 15; wb_data = 28'h0000001;
    cyc(); idle();
    rd(2, 15, 0, 0);
    check("dual_a", dout0, 28'hFFFFFFF);
    rd(3, 0, 15, 0);
    check("dual_b", dout1, 28'h0000001);
    check("dual_no_err", err, 0);

    // Scoreboard mark / clear
    mark_en = 1; mark_tid = 0; mark_reg = 7;
    cyc(); idle();
    rd(0, 0, 7, 0);
    check("mark_raw", hazard, 1);
    rd(0, 0, 0, 7);
    check("mark_waw", hazard, 1);
    rd(1, 0, 7, 0);
    check("mark_other_tid", hazard, 0);
    rd(0, 0, 7, 0);
    wb_en = 1; wb_tid = 0; wb_reg = 7; wb_data = 28'h1234567;
    #1;
`ifdef RF_BYPASS_EN
    check("wb_cycle_hazard", hazard, 0);
    check("wb_cycle_dout1", dout1, 28'h1234567);
`else
    check("wb_cycle_hazard", hazard, 1);
    check("wb_cycle_dout1", dout1, 0);
`endif
    cyc(); idle(); #1;
    check("wb_clear_hazard", hazard, 0);
    check("wb_data", dout1, 28'h1234567);

    // Mark vs clear, flush isolation
    mark_en = 1; mark_tid = 2; mark_reg = 4;
    cyc(); idle();
    mark_en = 1; mark_tid = 3; mark_reg = 4;
    wb_en = 1; wb_tid = 3; wb_reg = 4; wb_data = 28'h0000042;
    cyc(); idle();
    rd(3, 4, 0, 0);
    check("mark_beats_clr", hazard, 1);
    check("mark_clr_data", dout0, 28'h0000042);
    flush_en = 1; flush_tid = 3;
    cyc(); idle();
    rd(3, 4, 0, 0);
    check("flush_t3", hazard, 0);
    rd(2, 4, 0, 0);
    check("flush_keeps_t2", hazard, 1);

    // Flush vs same-cycle mark
    mark_en = 1; mark_tid = 3; mark_reg = 6;
    cyc(); idle();
    flush_en = 1; flush_tid = 3; mark_en = 1; mark_tid = 3; mark_reg = 5;
    cyc(); idle();
    rd(3, 5, 0, 0);
    check("mark_beats_flush", hazard, 1);
    rd(3, 6, 0, 0);
    check("flush_other_bit", hazard, 0);

    // Port A write to pending register keeps the bit
    wa_en = 1; wa_tid = 2; wa_reg = 4; wa_data = 28'h0000077;
    cyc(); idle();
    rd(2, 4, 0, 0);
    check("wa_pend_hazard", hazard, 1);
    check("wa_pend_data", dout0, 28'h0000077);

    // Port B write to non-pending register
    wb_en = 1; wb_tid = 0; wb_reg = 1; wb_data = 28'h5555555;
    cyc(); idle();
    rd(0, 1, 0, 0);
    check("wb_nopend_data", dout0, 28'h5555555);
    check("wb_nopend_hazard", hazard, 0);
    check("wb_nopend_err", err, 0);

    // Collision
    wa_en = 1; wa_tid = 1; wa_reg = 9; wa_data = 28'h1111111;
    wb_en = 1; wb_tid = 1; wb_reg = 9; wb_data = 28'h2222222;
    cyc(); idle();
    rd(1, 9, 0, 0);
    check("coll_data", dout0, 28'h1111111);
    check("coll_err", err, 1);
    cyc(); cyc();
    check("coll_err_sticky", err, 1);

    // Mid-operation asynchronous reset
    mark_en = 1; mark_tid = 0; mark_reg = 2;
    cyc(); idle();
    wa_en = 1; wa_tid = 0; wa_reg = 2; wa_data = 28'h3333333;
    cyc(); idle();
    rd(0, 2, 0, 0);
    check("pre_rst_hazard", hazard, 1);
    check("pre_rst_data", dout0, 28'h3333333);
    #1 rst = 1'b1;
    #1;
    check("async_rst_hazard", hazard, 0);
    check("async_rst_dout", dout0, 0);
    check("async_rst_err", err, 0);
    // Commands presented while rst is held across an edge are lost
    mark_en = 1; mark_tid = 0; mark_reg = 2;
    wa_en = 1; wa_tid = 0; wa_reg = 2; wa_data = 28'h4444444;
    cyc(); idle();
    #2 rst = 1'b0;
    #1;
    check("rst_lost_hazard", hazard, 0);
    check("rst_lost_dout", dout0, 0);
    rd(1, 9, 0, 0);
    check("rst_cleared_t1r9", dout0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Parametrised, multi-thread successor to the single-context thread register file. It holds NTHREADS banks of NREGS x DATA_W registers, with register 0 of every bank reading as zero. It has two read ports, two write ports (ALU result and late memory return) and a per-register pending scoreboard that flags RAW/WAW hazards to the issue stage. It sits between thread issue/decode and the ALU/load-return paths.

## Interface
- DATA_W, 28, register width in bits
- NREGS, 16, registers per thread (power of 2, >= 2); REG_W = $clog2(NREGS)
- NTHREADS, 4, thread banks (power of 2, >= 1); TID_W = max(1, $clog2(NTHREADS))
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_tid  in  TID_W  thread selected for both reads and the hazard check
- rs0, rs1  in  REG_W  read source selects
- rd_dst  in  REG_W  destination of the instruction under issue, used for the WAW check
- dout0, dout1  out  DATA_W  read data, combinational
- hazard  out  1  rs0, rs1 or rd_dst of rd_tid is pending; register 0 never hazards
- wa_en, wa_tid, wa_reg, wa_data  in  1/TID_W/REG_W/DATA_W  port A (ALU) write
- wb_en, wb_tid, wb_reg, wb_data  in  1/TID_W/REG_W/DATA_W  port B (memory return) write; clears pending
- mark_en, mark_tid, mark_reg  in  1/TID_W/REG_W  sets pending on a register when a load issues
- flush_en, flush_tid  in  1/TID_W  clears all pending bits of one thread
- err  out  1  sticky collision error

## Operation
- Storage: banks x registers 1..NREGS-1; register 0 has no storage.
- Reads:
  - dout = 0 when rs == 0.
  - Otherwise dout = stored value of bank[rd_tid][rs].
- Writes:
  - Port A and port B both write on the rising edge when enabled.
  - Writes to register 0 are discarded and affect no state.
- Same-register collision (wa_en & wb_en, same tid, same non-zero reg):
  - port A data is stored;
  - err sets and holds until rst.
  - Different targets both complete.
- Scoreboard: one bit per (tid, reg != 0).
  - mark sets the bit; a port B write clears it.
  - mark and port B clear on the same bit in the same cycle: mark wins and the bit stays set.
  - flush clears every bit of flush_tid, except a same-cycle mark to that tid, which wins.
  - Port B write to a non-pending register: data is stored, the bit stays 0, no error.
  - Port A write to a pending register: data is stored, the bit is unchanged.
- hazard = pend[rd_tid][rs0] | pend[rd_tid][rs1] | pend[rd_tid][rd_dst], with register 0 terms forced to 0.

## Timing
- Reset: all registers 0, all pending bits 0, err 0. Hence dout0 = dout1 = 0 and hazard = 0.
- rst asserted mid-operation clears state immediately. Writes and marks in that cycle are lost.
- Reads are zero-latency combinational; there are no read-side clocks.
- Write latency: without bypass, written data is visible on dout in the cycle after the enable edge.
- Pending latency:
  - The bit set by mark is visible on hazard in the next cycle.
  - The clear from port B takes effect in the next cycle, unless bypass is enabled.
- No handshakes. Producers must not assert port B for a tid while flush_en for that tid is high; if they do, data is written and flush still applies.

## Configuration
- RF_BYPASS_EN defined: same-cycle write forwarding.
  - A read matching (rd_tid, rs) of an enabled port A or B write returns that write's data, with port A having priority.
  - hazard ignores a pending bit being cleared by port B in the same cycle.
  - Register 0 is still forced to 0.
- RF_BYPASS_EN undefined: reads return stored data only, and hazard uses the registered pending bits only.

## Structure
- Package thread_rf_pkg:
  - default DATA_W/NREGS/NTHREADS;
  - derived REG_W/TID_W;
  - typedefs tid_t, reg_idx_t, word_t.
- Sub-module rf_scoreboard holds the pending bits and the mark/clear/flush priority logic, and outputs the pending vector per thread.
- Top level holds the data arrays, read muxes, optional bypass, and the collision/err logic.

## Test plan
- Reset then read: rst pulse, rd_tid=2, rs0=5, rs1=0 -> dout0=0, dout1=0, hazard=0, err=0.
- Port A write and read: wa tid1 r3 = 0x0ABCDEF, then rd_tid=1 rs0=3 next cycle -> dout0=0x0ABCDEF; rd_tid=0 rs0=3 -> 0. A write to r0 leaves dout=0.
- Scoreboard: mark tid0 r7, next cycle rs1=7 -> hazard=1; wb tid0 r7 = 0x1234567 -> next cycle hazard=0, dout1=0x1234567. With RF_BYPASS_EN: hazard=0 and dout1=0x1234567 in the wb cycle.
- Mark vs clear: mark and wb on tid3 r4 in the same cycle -> pending stays 1. Flush tid3 -> hazard for r4 = 0 next cycle. Flush tid3 does not affect tid2 pending bits.
- Collision: wa and wb on tid1 r9 with data 0x1111111 and 0x2222222 -> stored value 0x1111111, err=1 and stays 1 until rst.
- Mid-op reset: mark tid0 r2 and write r2, assert rst asynchronously between edges -> hazard=0, dout=0 immediately.
